// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchroniser, debouncer and press/release/long-press pulse generator
module btn_conditioner #(
  parameter int N_BTN       = 3,
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long
);
  localparam int DBW = $clog2(DB_CYCLES);
  localparam int HW  = $clog2(LONG_CYCLES + 1);
  logic [N_BTN-1:0] s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, tgl;
  logic [N_BTN-1:0] press_q, press_d, rel_q, rel_d, long_q, long_d;
  logic [DBW-1:0]   db_cnt_q [N_BTN];
  logic [DBW-1:0]   db_cnt_d [N_BTN];
  logic [HW-1:0]    hold_q   [N_BTN];
  logic [HW-1:0]    hold_d   [N_BTN];
  always_comb begin
    s1_d     = i_btn;
    s2_d     = s1_q;
    tgl      = '0;
    lvl_d    = lvl_q;
    press_d  = '0;
    rel_d    = '0;
    long_d   = '0;
    db_cnt_d = db_cnt_q;
    hold_d   = hold_q;
    for (int c = 0; c < N_BTN; c++) begin
      tgl[c]      = (s2_q[c] != lvl_q[c]) && (db_cnt_q[c] == DBW'(DB_CYCLES - 1));
      db_cnt_d[c] = (s2_q[c] == lvl_q[c] || tgl[c]) ? '0 : db_cnt_q[c] + DBW'(1);
      lvl_d[c]    = lvl_q[c] ^ tgl[c];
      press_d[c]  = tgl[c] & ~lvl_q[c];
      rel_d[c]    = tgl[c] & lvl_q[c];
      // a falling edge clears the hold count and suppresses a coincident long pulse
      hold_d[c]   = (!lvl_q[c] || tgl[c]) ? '0 :
                    (hold_q[c] == HW'(LONG_CYCLES)) ? hold_q[c] : hold_q[c] + HW'(1);
      long_d[c]   = lvl_q[c] && !tgl[c] && (hold_q[c] == HW'(LONG_CYCLES - 1));
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int c = 0; c < N_BTN; c++) begin
        db_cnt_q[c] <= '0;
        hold_q[c]   <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      lvl_q    <= lvl_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
    end
  end
  assign o_level   = lvl_q;
  assign o_press   = press_q;
  assign o_release = rel_q;
  assign o_long    = long_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random stimulus checked every cycle against a sample-window model
module tb_btn_conditioner;
  localparam int N = 3, DB = 4, L = 10;
  logic         i_clk = 1'b0, i_rst_n = 1'b0;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] o_level, o_press, o_release, o_long;
  int checks = 0, failures = 0;
  btn_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(L)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // the model sees what the DUT sampled at each rising edge, and whether that edge was out of reset
  logic [N-1:0] smp;
  logic         edge_ok = 1'b0;
  always @(posedge i_clk) begin
    smp     <= i_btn;
    edge_ok <= i_rst_n;
  end
  // model: level toggles when the last DB synchronised samples all disagree with it
  logic [N-1:0] raw_q[$], s2_hist[$];
  logic [N-1:0] m_lvl, e_press, e_rel, e_long, m_s2;
  logic         m_tgl;
  int           step, rise[N];
  initial begin
    m_lvl = '0; e_press = '0; e_rel = '0; e_long = '0; step = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        raw_q.delete(); s2_hist.delete();
        m_lvl = '0; e_press = '0; e_rel = '0; e_long = '0; step = 0;
      end else if (edge_ok) begin
        m_s2 = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
        raw_q.push_back(smp);
        s2_hist.push_back(m_s2);
        step++;
        for (int c = 0; c < N; c++) begin
          m_tgl = 1'b0;
          if (s2_hist.size() >= DB) begin
            m_tgl = 1'b1;
            for (int j = 0; j < DB; j++)
              if (s2_hist[s2_hist.size()-1-j][c] == m_lvl[c]) m_tgl = 1'b0;
          end
          e_press[c] = m_tgl && !m_lvl[c];
          e_rel[c]   = m_tgl && m_lvl[c];
          e_long[c]  = m_lvl[c] && !m_tgl && (step - rise[c] == L);
          if (m_tgl) begin
            m_lvl[c] = !m_lvl[c];
            if (m_lvl[c]) rise[c] = step;
          end
        end
        while (raw_q.size() > 16) void'(raw_q.pop_front());
        while (s2_hist.size() > 16) void'(s2_hist.pop_front());
      end
      chk("model_level", o_level, m_lvl);
      chk("model_press", o_press, e_press);
      chk("model_release", o_release, e_rel);
      chk("model_long", o_long, e_long);
    end
  end
  task automatic edges(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask
  initial begin
    edges(2);
    i_rst_n = 1'b1;
    edges(20);
    chk("idle_level", o_level, 3'b000);
    // single press on channel 0: drive before edge k, level rises at edge k+5
    i_btn = 3'b001;
    edges(5);
    chk("press0_early", o_level, 3'b000);
    edges(1);
    chk("press0_level", o_level, 3'b001);
    chk("press0_pulse", o_press, 3'b001);
    edges(1);
    chk("press0_once", o_press, 3'b000);
    i_btn = 3'b000;
    edges(10);
    // bouncing channel 1 never settles long enough
    for (int r = 0; r < 5; r++) begin
      i_btn[1] = 1'b1; edges(3);
      i_btn[1] = 1'b0; edges(1);
      i_btn[1] = 1'b1; edges(2);
      i_btn[1] = 1'b0; edges(1);
    end
    chk("bounce_level", o_level, 3'b000);
    i_btn[1] = 1'b1;
    edges(6);
    chk("bounce_press", o_press, 3'b010);
    i_btn[1] = 1'b0;
    edges(10);
    // long press on channel 2
    i_btn[2] = 1'b1;
    edges(15);
    chk("long_early", o_long, 3'b000);
    edges(1);
    chk("long_pulse", o_long, 3'b100);
    edges(1);
    chk("long_once", o_long, 3'b000);
    edges(20);
    i_btn[2] = 1'b0;
    edges(6);
    chk("long_release", o_release, 3'b100);
    edges(3);
    // release 9 edges after the rise: no long pulse
    i_btn[0] = 1'b1;
    edges(9);
    i_btn[0] = 1'b0;
    edges(6);
    chk("short_release", o_release, 3'b001);
    edges(1);
    chk("short_no_long", o_long, 3'b000);
    edges(10);
    // asynchronous reset while channel 0 is held
    i_btn[0] = 1'b1;
    edges(10);
    chk("pre_reset_level", o_level, 3'b001);
    #1 i_rst_n = 1'b0;
    #1 chk("reset_now", {o_level, o_press, o_release, o_long}, 12'h000);
    repeat (3) @(posedge i_clk);
    #4 i_rst_n = 1'b1;
    edges(5);
    chk("rearm_early", o_press, 3'b000);
    edges(1);
    chk("rearm_press", o_press, 3'b001);
    i_btn = 3'b000;
    edges(10);
    // random: fast toggling, then slower holds that reach long presses
    for (int t = 0; t < 800; t++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 5) == 0) i_btn[c] = ~i_btn[c];
      edges(1);
    end
    for (int t = 0; t < 1200; t++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 30) == 0) i_btn[c] = ~i_btn[c];
      edges(1);
    end
    i_btn = 3'b000;
    edges(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
